// File: rtl/seq_timer.sv
// Programmable down-counter peripheral on the sequencer command bus.
// Accepts {cmd,arg} words and returns either the count or a status byte for polling.
module seq_timer (
    input  logic        clock,
    input  logic        reset,
    input  logic [11:0] inst,
    input  logic        inst_en,
    output logic [7:0]  out
);

    localparam int unsigned CMD_W  = 4;
    localparam int unsigned DATA_W = 8;

    localparam logic [CMD_W-1:0] CMD_LDC = 4'd1;
    localparam logic [CMD_W-1:0] CMD_LDP = 4'd2;
    localparam logic [CMD_W-1:0] CMD_RUN = 4'd3;
    localparam logic [CMD_W-1:0] CMD_STP = 4'd4;
    localparam logic [CMD_W-1:0] CMD_RDC = 4'd5;
    localparam logic [CMD_W-1:0] CMD_RDS = 4'd6;
    localparam logic [CMD_W-1:0] CMD_ACK = 4'd7;

    typedef enum logic [1:0] {
        ST_RESET = 2'd0,
        ST_READY = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t              state;
    state_t              state_next;
    logic [DATA_W-1:0]   cnt;
    logic [DATA_W-1:0]   rld;
    logic [DATA_W-1:0]   pre;
    logic                sel;
    logic                exp;

    logic [CMD_W-1:0]    cmd;
    logic [DATA_W-1:0]   arg;
    logic                take;
    logic                tick;
    logic                wrap;
    logic                is_ldc;
    logic                start;
    logic                expire;

    assign cmd    = inst[11:8];
    assign arg    = inst[7:0];
    assign take   = inst_en && (state == ST_READY || state == ST_RUN);
    assign is_ldc = take && (cmd == CMD_LDC);
    // STP suppresses the tick entirely; LDC only suppresses the count decrement.
    assign tick   = (state == ST_RUN) && !(take && cmd == CMD_STP);
    assign wrap   = tick && (pre == '0);
    assign start  = take && (state == ST_READY) && (cmd == CMD_RUN);
    assign expire = (wrap && !is_ldc && cnt == DATA_W'(1))
                  || (start && cnt == '0);

    always_ff @(posedge clock) begin
        if (reset) begin
            state <= ST_RESET;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            ST_RESET: state_next = ST_READY;
            ST_READY: begin
                if (take && cmd[3]) begin
                    state_next = ST_ERROR;
                end else if (start && cnt != '0) begin
                    state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (take && cmd[3]) begin
                    state_next = ST_ERROR;
                end else if (take && cmd == CMD_STP) begin
                    state_next = ST_READY;
                end else if (is_ldc) begin
                    if (arg == '0) begin
                        state_next = ST_READY;
                    end
                end else if (wrap && cnt == DATA_W'(1)) begin
                    state_next = ST_READY;
                end
            end
            default: state_next = ST_ERROR;
        endcase
    end

    always_comb begin
        out = '0;
        if (state == ST_READY || state == ST_RUN) begin
            if (sel) begin
                out = {5'b0, 1'b0, exp, (state == ST_RUN)};
            end else begin
                out = cnt;
            end
        end
    end

    // Counter, prescaler and control registers; frozen outside Ready/Run via take/tick.
    always_ff @(posedge clock) begin
        if (reset) begin
            cnt <= '0;
            rld <= '0;
            pre <= '0;
            sel <= 1'b0;
            exp <= 1'b0;
        end else begin
            if (is_ldc) begin
                cnt <= arg;
            end else if (wrap) begin
                cnt <= DATA_W'(cnt - DATA_W'(1));
            end

            if (start && cnt != '0) begin
                pre <= rld;
            end else if (tick) begin
                pre <= wrap ? rld : DATA_W'(pre - DATA_W'(1));
            end

            if (take && cmd == CMD_LDP) begin
                rld <= arg;
            end

            if (take && cmd == CMD_RDC) begin
                sel <= 1'b0;
            end else if (take && cmd == CMD_RDS) begin
                sel <= 1'b1;
            end

            if (expire) begin
                exp <= 1'b1;
            end else if (take && cmd == CMD_ACK) begin
                exp <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_seq_timer.sv
// Directed bench for seq_timer: a per-cycle behavioural model checked on every
// falling edge, plus literal expectations after each command.
module tb_seq_timer;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [11:0] inst  = '0;
    logic        inst_en = 1'b0;
    wire  [7:0]  out;

    int checks = 0;
    int passes = 0;
    bit armed  = 1'b0;

    // Model state: 0 Reset, 1 Ready, 2 Run, 3 Error
    int m_st = 0;
    int m_cnt = 0, m_rld = 0, m_pre = 0;
    bit m_sel = 1'b0, m_exp = 1'b0;

    seq_timer dut (
        .clock   (clock),
        .reset   (reset),
        .inst    (inst),
        .inst_en (inst_en),
        .out     (out)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] model_out();
        if (m_st == 0 || m_st == 3) return 8'h00;
        if (m_sel) return {6'b0, m_exp, (m_st == 2)};
        return 8'(m_cnt);
    endfunction

    // One clock of the timer, applied from the command rules in plain arithmetic.
    task automatic model_step(input bit rst, input bit en, input logic [11:0] ins);
        int cmd, arg;
        int n_st, n_cnt, n_pre, n_rld;
        bit n_sel, n_exp, expired;
        if (rst) begin
            m_st = 0; m_cnt = 0; m_rld = 0; m_pre = 0; m_sel = 0; m_exp = 0;
            return;
        end
        if (m_st == 0) begin m_st = 1; return; end
        if (m_st == 3) return;
        cmd = int'(ins[11:8]);
        arg = int'(ins[7:0]);
        n_st = m_st; n_cnt = m_cnt; n_pre = m_pre; n_rld = m_rld;
        n_sel = m_sel; n_exp = m_exp; expired = 0;
        if (m_st == 2 && !(en && cmd == 4)) begin
            if (m_pre == 0) begin
                n_pre = m_rld;
                if (!(en && cmd == 1)) begin
                    n_cnt = m_cnt - 1;
                    if (m_cnt == 1) begin n_exp = 1; n_st = 1; expired = 1; end
                end
            end else begin
                n_pre = m_pre - 1;
            end
        end
        if (en) begin
            case (cmd)
                1: begin n_cnt = arg; if (m_st == 2 && arg == 0) n_st = 1; end
                2: n_rld = arg;
                3: if (m_st == 1) begin
                       if (m_cnt != 0) begin n_pre = m_rld; n_st = 2; end
                       else begin n_exp = 1; expired = 1; end
                   end
                4: n_st = 1;
                5: n_sel = 0;
                6: n_sel = 1;
                7: if (!expired) n_exp = 0;
                default: if (cmd >= 8) n_st = 3;
            endcase
        end
        m_st = n_st; m_cnt = n_cnt; m_pre = n_pre; m_rld = n_rld;
        m_sel = n_sel; m_exp = n_exp;
    endtask

    // Drive one cycle of inputs, advance the model on the edge.
    task automatic cyc(input bit rst, input bit en, input logic [11:0] ins);
        @(negedge clock);
        reset = rst; inst_en = en; inst = ins;
        @(posedge clock);
        model_step(rst, en, ins);
        #1;
    endtask

    task automatic expect_out(input string nm, input logic [7:0] want);
        checks++;
        if (out === want) passes++;
        else $display("FAIL %s: out=0x%02h required 0x%02h", nm, out, want);
    endtask

    always @(negedge clock) begin
        if (armed) begin
            checks++;
            if (out === model_out()) passes++;
            else $display("FAIL model t=%0t: out=0x%02h required 0x%02h", $time, out, model_out());
        end
    end

    initial begin
        cyc(1, 0, 12'h000);              expect_out("reset", 8'h00);
        armed = 1'b1;
        cyc(0, 0, 12'h000);              expect_out("idle_ready", 8'h00);

        // count 3 with rld=0
        cyc(0, 1, 12'h103);              expect_out("ldc3", 8'h03);
        cyc(0, 1, 12'h500);              expect_out("rdc", 8'h03);
        cyc(0, 1, 12'h300);              expect_out("run3_0", 8'h03);
        cyc(0, 0, 12'h000);              expect_out("run3_1", 8'h02);
        cyc(0, 0, 12'h000);              expect_out("run3_2", 8'h01);
        cyc(0, 0, 12'h000);              expect_out("run3_3", 8'h00);
        cyc(0, 1, 12'h600);              expect_out("rds_exp", 8'h02);
        cyc(0, 1, 12'h700);              expect_out("ack1", 8'h00);

        // prescaled run: 2*(2+1) = 6 cycles of running
        cyc(0, 1, 12'h202);              expect_out("ldp2", 8'h00);
        cyc(0, 1, 12'h102);              expect_out("ldc2", 8'h00);
        cyc(0, 1, 12'h300);              expect_out("prun_0", 8'h01);
        for (int i = 1; i < 6; i++) begin
            cyc(0, 0, 12'h000);          expect_out("prun_mid", 8'h01);
        end
        cyc(0, 0, 12'h000);              expect_out("prun_end", 8'h02);
        cyc(0, 1, 12'h700);              expect_out("ack2", 8'h00);

        // RUN with cnt=0 expires immediately without running
        cyc(0, 1, 12'h300);              expect_out("run_zero", 8'h02);
        cyc(0, 1, 12'h700);              expect_out("ack3", 8'h00);

        // stop and resume
        cyc(0, 1, 12'h200);              expect_out("ldp0", 8'h00);
        cyc(0, 1, 12'h500);              expect_out("rdc2", 8'h00);
        cyc(0, 1, 12'h105);              expect_out("ldc5", 8'h05);
        cyc(0, 1, 12'h300);              expect_out("run5", 8'h05);
        cyc(0, 0, 12'h000);              expect_out("tick4", 8'h04);
        cyc(0, 0, 12'h000);              expect_out("tick3", 8'h03);
        cyc(0, 1, 12'h400);              expect_out("stp", 8'h03);
        cyc(0, 0, 12'h000);              expect_out("hold", 8'h03);
        cyc(0, 1, 12'h300);              expect_out("resume", 8'h03);
        cyc(0, 0, 12'h000);              expect_out("res2", 8'h02);
        cyc(0, 0, 12'h000);              expect_out("res1", 8'h01);
        cyc(0, 0, 12'h000);              expect_out("res0", 8'h00);
        cyc(0, 1, 12'h600);              expect_out("rds_res", 8'h02);
        cyc(0, 1, 12'h700);              expect_out("ack4", 8'h00);

        // ACK coinciding with expiry loses to the expiry
        cyc(0, 1, 12'h101);              expect_out("ldc1", 8'h00);
        cyc(0, 1, 12'h300);              expect_out("run1", 8'h01);
        cyc(0, 1, 12'h700);              expect_out("ack_vs_exp", 8'h02);
        cyc(0, 1, 12'h700);              expect_out("ack5", 8'h00);

        // LDC 0 while running stops without expiry
        cyc(0, 1, 12'h104);              expect_out("ldc4", 8'h00);
        cyc(0, 1, 12'h300);              expect_out("run4", 8'h01);
        cyc(0, 1, 12'h100);              expect_out("ldc0_run", 8'h00);

        // Error is sticky, then reset recovers
        cyc(0, 1, 12'h9AB);              expect_out("err", 8'h00);
        cyc(0, 1, 12'h1FF);              expect_out("err_ldc", 8'h00);
        cyc(0, 1, 12'h500);              expect_out("err_rdc", 8'h00);
        cyc(0, 1, 12'h300);              expect_out("err_run", 8'h00);
        cyc(1, 0, 12'h000);              expect_out("reset2", 8'h00);
        cyc(0, 1, 12'h1AA);              expect_out("reset_ignored", 8'h00);
        cyc(0, 1, 12'h107);              expect_out("ready_ldc7", 8'h07);

        // reset mid-run loses count and flag
        cyc(0, 1, 12'h300);              expect_out("run7", 8'h07);
        cyc(1, 0, 12'h000);              expect_out("reset_run", 8'h00);
        cyc(0, 0, 12'h000);              expect_out("after_reset", 8'h00);
        cyc(0, 1, 12'h600);              expect_out("rds_clean", 8'h00);

        armed = 1'b0;
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
